tx_link_seq: RTL
================

// Module: tx_link_seq
// PURPOSE
//  Upstream stage of tx_char_replace in the JESD204B TX lane: link-layer sequencer, 4 octets/clock.
//  - Keeps the LMFC beat counter.
//  - Runs CGS -> ILAS -> DATA on SYNC_n.
//  - Drives DO/DO_K plus aligned FE/ME/EN, which are fed straight into tx_char_replace DI/DI_K/FE/ME/EN.
// PARAMETERS
//  SYNC_MIN  4  consecutive SYNC_n-low cycles in ILAS/DATA that force re-sync (CGS)
//  ILAS_MF   4  number of ILAS multiframes
// PORTS
//  CLK     in   1        clock
//  RST_n   in   1        synchronous, active-low reset
//  F       in   8        octets per frame minus 1; legal: 0, 1, or (F+1) multiple of 4
//  K       in   5        frames per multiframe minus 1; (F+1)*(K+1) multiple of 4 and >= 20
//  SYNC_n  in   1        receiver sync request, already synchronised to CLK
//  SYSREF  in   1        LMFC alignment strobe, synchronised
//  CFG     in   14x8     ILAS link-config octets, CFG[0] sent first
//  DI      in   4x8      user data; DI[0] is the earliest octet
//  DI_RDY  out  1        DI consumed this cycle
//  DO      out  4x8      lane octets
//  DO_K    out  4        per-octet control flag
//  FE      out  4        frame-end flag per octet
//  ME      out  4        multiframe-end flag per octet
//  EN      out  1        data phase, char replacement enabled
//  LMFC    out  1        one-cycle pulse on beat 0 of each multiframe
// BEHAVIOUR
//  Multiframe and LMFC counter
//  - MFB = (F+1)*(K+1)/4 beats, 11 bits, recomputed into a register every cycle.
//  - F and K are static while out of reset.
//  - beat counter b: 0..MFB-1, wraps, LMFC=1 when b==0.
//  - SYSREF rising edge (previous-cycle sample 0, current 1): b=0 next cycle, counter then continues normally; no state change.
//  State machine
//  - States: CGS, ILAS, DATA. Reset enters CGS with b=0 and an all-zero output register.
//  - CGS: all octets K28.5 (0xBC, K=1).
//    - Once SYNC_n==1, moves to ILAS on the cycle where b wraps to 0, so ILAS starts on beat 0.
//    - If SYNC_n goes back to 0 before the wrap, stays in CGS.
//  - ILAS: ILAS_MF multiframes, m = 0..ILAS_MF-1; octet index o = 4*b+i.
//    - o==0: K28.0 (0x1C, K).
//    - o==4*MFB-1: K28.3 (0x7C, K).
//    - m==1 only: o==1 is K28.4 (0x9C, K); o==2..15 carry CFG[o-2] (D).
//    - All other octets: o[7:0] (D ramp).
//    - After the last beat of m==ILAS_MF-1: DATA.
//  - DATA: DO=DI, DO_K=0, EN=1, DI_RDY=1.
//  - Re-sync: in ILAS or DATA, SYNC_n low for SYNC_MIN consecutive cycles -> CGS on the next cycle.
//    - A shorter low pulse is ignored.
//    - A new ILAS again waits for SYNC_n high plus an LMFC wrap.
//  Outputs
//  - All outputs registered, 1-cycle latency: DI sampled in cycle t appears on DO in t+1.
//  - DI_RDY is combinational from state; it is high in the cycle DI is sampled.
//  - FE/ME/EN are aligned with the DO beat they describe.
//  - FE, asserted in every state:
//    - F==0: 4'b1111.
//    - F==1: 4'b1010.
//    - Otherwise FE[3] on the last beat of each frame (frame beat counter = (F+1)/4-1); FE[2:0]=0.
//    - The frame beat counter resets with b.
//  - ME[3] on beat b==MFB-1; ME[2:0]=0.
//  - EN=1 only on DO beats originating in DATA.
//  - Reset: DO=0, DO_K=0, FE=0, ME=0, EN=0, DI_RDY=0, LMFC=0.
//  - Reset asserted mid-ILAS or mid-DATA: the next cycle shows reset values; resumes in CGS.
// TESTING
//  1. Reset, F=1, K=31 (MFB=16), SYNC_n=0:
//     DO = four 0xBC octets, DO_K=4'hF; FE=4'b1010; ME=4'b1000 and LMFC=1 every 16 cycles.
//  2. Raise SYNC_n mid-multiframe:
//     - ILAS starts at the next b==0: first octet 0x1C K, octet 63 0x7C K.
//     - MF1: octet 1 0x9C K, octets 2..15 = CFG.
//     - EN rises exactly 64 cycles after ILAS start.
//  3. DATA with DI incrementing: DO equals DI delayed 1 cycle, DO_K=0, EN=1, DI_RDY=1.
//  4. SYNC_n low 3 cycles in DATA -> no change; low 4 cycles -> DO=0xBC x4 the next cycle, EN=0.
//  5. F=3, K=4 (MFB=5): FE=4'b1000 every beat, ME[3] every 5th beat.
//     SYSREF pulse mid-multiframe -> LMFC re-aligns the following cycle.
//  6. RST_n low during ILAS beat 30 -> all outputs zero next cycle; then CGS, then ILAS restarts from m=0.

Source files
------------

// File: rtl/tx_link_seq.sv
// JESD204B TX link-layer sequencer, 4 octets per clock: LMFC beat counter,
// CGS -> ILAS -> DATA sequencing on SYNC_n, and registered DO/DO_K/FE/ME/EN.
module tx_link_seq #(
  parameter int SYNC_MIN = 4,
  parameter int ILAS_MF  = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [7:0]       i_F,
  input  logic [4:0]       i_K,
  input  logic             i_SYNC_n,
  input  logic             i_SYSREF,
  input  logic [13:0][7:0] i_CFG,
  input  logic [3:0][7:0]  i_DI,
  output logic             o_DI_RDY,
  output logic [3:0][7:0]  o_DO,
  output logic [3:0]       o_DO_K,
  output logic [3:0]       o_FE,
  output logic [3:0]       o_ME,
  output logic             o_EN,
  output logic             o_LMFC
);

  typedef enum logic [1:0] {ST_CGS, ST_ILAS, ST_DATA} state_t;

  state_t          r_state, w_state_next;
  logic [8:0]      w_f1;
  logic [5:0]      w_k1;
  logic [13:0]     w_prod;
  logic [10:0]     r_mfb;
  logic [7:0]      r_fpb_m1;
  logic [10:0]     r_b, w_b_next;
  logic [7:0]      r_fb, w_fb_next;
  logic            r_sysref_d;
  logic [7:0]      r_m;
  logic [7:0]      r_low;
  logic            w_mf_last, w_resync, w_sysref_rise;
  logic [3:0][7:0] w_ilas_do;
  logic [3:0]      w_ilas_k;
  logic [3:0][7:0] w_do_next;
  logic [3:0]      w_dok_next, w_fe_next;
  logic            w_en_next;

  assign w_f1   = {1'b0, i_F} + 9'd1;
  assign w_k1   = {1'b0, i_K} + 6'd1;
  assign w_prod = 14'(w_f1) * 14'(w_k1);

  always_ff @(posedge CLK) begin
    r_mfb    <= 11'(w_prod >> 2);
    r_fpb_m1 <= 8'((w_f1 >> 2) - 9'd1);
  end

  assign w_sysref_rise = i_SYSREF & ~r_sysref_d;
  assign w_mf_last     = (r_b == r_mfb - 11'd1);
  assign w_resync      = (r_state != ST_CGS) && !i_SYNC_n && (r_low == 8'(SYNC_MIN - 1));

  // Frame beat counter restarts together with the multiframe beat counter.
  always_comb begin
    w_b_next  = r_b + 11'd1;
    w_fb_next = r_fb + 8'd1;
    if (w_sysref_rise || w_mf_last) begin
      w_b_next  = '0;
      w_fb_next = '0;
    end else if (r_fb == r_fpb_m1) begin
      w_fb_next = '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_DI_RDY     = 1'b0;
    unique case (r_state)
      ST_CGS:  if (i_SYNC_n && w_b_next == 11'd0) w_state_next = ST_ILAS;
      ST_ILAS: begin
        if (w_resync) w_state_next = ST_CGS;
        else if (w_mf_last && r_m == 8'(ILAS_MF - 1)) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        o_DI_RDY = !w_resync;
        if (w_resync) w_state_next = ST_CGS;
      end
      default: w_state_next = ST_CGS;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_state    <= ST_CGS;
      r_b        <= '0;
      r_fb       <= '0;
      r_sysref_d <= 1'b0;
      r_m        <= '0;
      r_low      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_b        <= w_b_next;
      r_fb       <= w_fb_next;
      r_sysref_d <= i_SYSREF;
      r_m        <= (r_state == ST_ILAS && w_state_next == ST_ILAS) ?
                    (w_mf_last ? r_m + 8'd1 : r_m) : 8'd0;
      r_low      <= (r_state != ST_CGS && !i_SYNC_n && !w_resync) ? r_low + 8'd1 : 8'd0;
    end
  end

  // ILAS octet o = 4*b + lane; multiframe 1 carries the link configuration.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ilas
    logic [12:0] w_o;
    logic [7:0]  w_oct;
    logic        w_k;
    assign w_o = {r_b, 2'(gi)};
    always_comb begin
      w_oct = w_o[7:0];
      w_k   = 1'b0;
      if (w_o == 13'd0) begin
        w_oct = 8'h1C;
        w_k   = 1'b1;
      end else if (w_o == {r_mfb - 11'd1, 2'b11}) begin
        w_oct = 8'h7C;
        w_k   = 1'b1;
      end else if (r_m == 8'd1 && w_o == 13'd1) begin
        w_oct = 8'h9C;
        w_k   = 1'b1;
      end else if (r_m == 8'd1 && w_o >= 13'd2 && w_o <= 13'd15) begin
        w_oct = i_CFG[w_o[3:0] - 4'd2];
      end
    end
    assign w_ilas_do[gi] = w_oct;
    assign w_ilas_k[gi]  = w_k;
  end

  // A re-sync already shows CGS characters on the beat that triggers it.
  always_comb begin
    w_do_next  = {4{8'hBC}};
    w_dok_next = 4'hF;
    w_en_next  = 1'b0;
    if (!w_resync) begin
      case (r_state)
        ST_ILAS: begin
          w_do_next  = w_ilas_do;
          w_dok_next = w_ilas_k;
        end
        ST_DATA: begin
          w_do_next  = i_DI;
          w_dok_next = 4'h0;
          w_en_next  = 1'b1;
        end
        default: ;
      endcase
    end
    if (i_F == 8'd0)      w_fe_next = 4'b1111;
    else if (i_F == 8'd1) w_fe_next = 4'b1010;
    else                  w_fe_next = {r_fb == r_fpb_m1, 3'b000};
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      o_DO   <= '0;
      o_DO_K <= '0;
      o_FE   <= '0;
      o_ME   <= '0;
      o_EN   <= 1'b0;
      o_LMFC <= 1'b0;
    end else begin
      o_DO   <= w_do_next;
      o_DO_K <= w_dok_next;
      o_FE   <= w_fe_next;
      o_ME   <= {w_mf_last, 3'b000};
      o_EN   <= w_en_next;
      o_LMFC <= (r_b == 11'd0);
    end
  end

endmodule
